// File: rtl/trg_sched.sv
// Trigger scheduler: arbitrates external and periodic trigger sources, applies the busy veto
// and hold-off, and issues one conditioned pulse per grant with issued/missed counters.
module trg_sched #(
    parameter int NSRC = 4,
    parameter int SIDW = 3,
    parameter int CNTW = 16,
    parameter int PLW  = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            en_i,
    input  logic [NSRC-1:0] src_mask_i,
    input  logic [NSRC-1:0] trg_req_i,
    input  logic            busy_i,
    input  logic [CNTW-1:0] period_i,
    input  logic [PLW-1:0]  pulse_len_i,
    input  logic [CNTW-1:0] holdoff_i,
    output logic            trg_o,
    output logic [SIDW-1:0] trg_id_o,
    output logic [CNTW-1:0] trg_cnt_o,
    output logic [CNTW-1:0] miss_cnt_o,
    output logic            busy_o,
    output logic [1:0]      dbg_state_o
);

    localparam int NP = NSRC + 1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] req_s_q, req_s_d;
    logic [NSRC-1:0] req_p_q, req_p_d;
    logic [CNTW-1:0] per_q, per_d;
    logic [NP-1:0]   pend_q, pend_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [CNTW-1:0] hold_q, hold_d;
    logic            trg_q, trg_d;
    logic [SIDW-1:0] id_q, id_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] miss_q, miss_d;
    logic            busy_q, busy_d;

    logic            per_edge;
    logic [NP-1:0]   edges;
    logic [NP-1:0]   gnt_oh;
    logic [SIDW-1:0] gnt_idx;
    logic [PLW-1:0]  plen_eff;

    // Input stage: requests are registered once before edge detection, so an edge
    // sampled at clock k reaches pend at k+1 and the pulse at k+2.
    always_comb begin
        req_s_d  = trg_req_i;
        req_p_d  = req_s_q;
        per_d    = '0;
        per_edge = 1'b0;
        if (en_i && period_i != '0) begin
            if (per_q >= period_i - CNT_ONE) begin
                per_edge = 1'b1;
            end else begin
                per_d = per_q + CNT_ONE;
            end
        end
        // With the scheduler disabled no edge is recorded, pended or counted as a miss.
        edges = en_i ? {per_edge, req_s_q & ~req_p_q & src_mask_i} : '0;
    end

    always_comb begin
        gnt_oh  = pend_q & (~pend_q + NP'(1));
        gnt_idx = '0;
        for (int i = NSRC; i >= 0; i--) begin
            if (pend_q[i]) begin
                gnt_idx = SIDW'(i);
            end
        end
        plen_eff = (pulse_len_i == '0) ? PLW'(1) : pulse_len_i;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        case (state_q)
            ST_IDLE: begin
                pend_d = pend_q | edges;
                if (en_i && pend_q != '0 && !busy_i) begin
                    pend_d  = (pend_q & ~gnt_oh) | edges;
                    id_d    = gnt_idx;
                    cnt_d   = cnt_q + CNT_ONE;
                    rem_d   = CNTW'(plen_eff) - CNT_ONE;
                    hold_d  = holdoff_i;
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - CNT_ONE;
                end else if (hold_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = hold_q - CNT_ONE;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Edges on bits already pending are absorbed; only new ones count as misses.
        if (state_q != ST_IDLE && (edges & ~pend_q) != '0 && miss_q != '1) begin
            miss_d = miss_q + CNT_ONE;
        end
        if (!en_i) begin
            pend_d = '0;
        end
        trg_d  = (state_d == ST_FIRE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            req_s_q <= '0;
            req_p_q <= '0;
            per_q   <= '0;
            pend_q  <= '0;
            rem_q   <= '0;
            hold_q  <= '0;
            trg_q   <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
            miss_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_s_q <= req_s_d;
            req_p_q <= req_p_d;
            per_q   <= per_d;
            pend_q  <= pend_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            trg_q   <= trg_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
        end
    end

    assign trg_o       = trg_q;
    assign trg_id_o    = id_q;
    assign trg_cnt_o   = cnt_q;
    assign miss_cnt_o  = miss_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trg_sched.sv
// Self-checking bench for trg_sched: directed scenarios plus random traffic, scored against
// a transaction-level model (pending set, busy-time budget, counters).
module tb_trg_sched;

    localparam int NSRC = 4;
    localparam int SIDW = 3;
    localparam int CNTW = 16;
    localparam int PLW  = 4;
    localparam int EW   = 48;

    logic            clk;
    logic            rst_n;
    logic            en_i;
    logic [NSRC-1:0] src_mask_i;
    logic [NSRC-1:0] trg_req_i;
    logic            busy_i;
    logic [CNTW-1:0] period_i;
    logic [PLW-1:0]  pulse_len_i;
    logic [CNTW-1:0] holdoff_i;
    logic            trg_o;
    logic [SIDW-1:0] trg_id_o;
    logic [CNTW-1:0] trg_cnt_o;
    logic [CNTW-1:0] miss_cnt_o;
    logic            busy_o;
    logic [1:0]      dbg_state_o;

    trg_sched #(.NSRC(NSRC), .SIDW(SIDW), .CNTW(CNTW), .PLW(PLW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en_i),
        .src_mask_i  (src_mask_i),
        .trg_req_i   (trg_req_i),
        .busy_i      (busy_i),
        .period_i    (period_i),
        .pulse_len_i (pulse_len_i),
        .holdoff_i   (holdoff_i),
        .trg_o       (trg_o),
        .trg_id_o    (trg_id_o),
        .trg_cnt_o   (trg_cnt_o),
        .miss_cnt_o  (miss_cnt_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Reference model: pending sources as a set, sequencer as a remaining-busy-cycles budget.
    logic [EW-1:0]   exp_q[$];
    int              cyc;
    int              pc;
    int              busy_left;
    logic [NSRC:0]   m_pend;
    logic [NSRC-1:0] req_h1, req_h2;
    int              m_cnt;
    int              m_miss;
    int              m_id;
    logic            m_busy;

    task automatic model_reset();
        exp_q.delete();
        pc        = 0;
        busy_left = 0;
        m_pend    = '0;
        req_h1    = '0;
        req_h2    = '0;
        m_cnt     = 0;
        m_miss    = 0;
        m_id      = 0;
        m_busy    = 1'b0;
    endtask

    task automatic model_step();
        logic [NSRC:0] edges;
        int            g;
        int            plen;
        cyc++;
        edges = '0;
        if (en_i) begin
            edges[NSRC-1:0] = req_h1 & ~req_h2 & src_mask_i;
            if (period_i != 0) begin
                if (pc >= int'(period_i) - 1) begin
                    edges[NSRC] = 1'b1;
                    pc = 0;
                end else begin
                    pc++;
                end
            end else begin
                pc = 0;
            end
        end else begin
            pc = 0;
        end
        req_h2 = req_h1;
        req_h1 = trg_req_i;
        if (busy_left > 0) begin
            busy_left--;
            if ((edges & ~m_pend) != 0 && m_miss < 65535) m_miss++;
            if (!en_i) m_pend = '0;
        end else if (!en_i) begin
            m_pend = '0;
        end else begin
            if (m_pend != 0 && !busy_i) begin
                g = 0;
                while (!m_pend[g]) g++;
                m_pend[g] = 1'b0;
                m_cnt     = (m_cnt + 1) % 65536;
                m_id      = g;
                plen      = (pulse_len_i == 0) ? 1 : int'(pulse_len_i);
                busy_left = plen + int'(holdoff_i);
                exp_q.push_back({cyc[31:0], 8'(g), 8'(plen)});
            end
            m_pend = m_pend | edges;
        end
        m_busy = (busy_left > 0);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: pops one expected pulse per observed rising edge of trg_o.
    initial begin
        logic          in_pulse;
        int            cur_len;
        int            exp_len;
        logic [EW-1:0] e;
        in_pulse = 1'b0;
        cur_len  = 0;
        exp_len  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) in_pulse = 1'b0;
            chk("busy_o", busy_o, m_busy);
            chk("miss_cnt_o", miss_cnt_o, m_miss);
            chk("trg_cnt_o", trg_cnt_o, m_cnt);
            chk("trg_id_o", trg_id_o, m_id);
            if (trg_o && !in_pulse) begin
                chk("pulse_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e[47:16]);
                    chk("pulse_id", trg_id_o, e[15:8]);
                    exp_len = int'(e[7:0]);
                end
                in_pulse = 1'b1;
                cur_len  = 1;
            end else if (trg_o) begin
                cur_len++;
            end else if (in_pulse) begin
                chk("pulse_len", cur_len, exp_len);
                in_pulse = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [NSRC-1:0] mask, input int plen, input int hold, input int period);
        src_mask_i  = mask;
        pulse_len_i = PLW'(plen);
        holdoff_i   = CNTW'(hold);
        period_i    = CNTW'(period);
    endtask

    task automatic wait_trg(input int budget, input string name);
        int found = 0;
        for (int k = 0; k < budget && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (trg_o) found = 1;
        end
        chk(name, found, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en_i = 1'b1;
        busy_i = 1'b0;
        trg_req_i = '0;
        set_cfg(4'hF, 4, 3, 0);
        idle_cycles(3);
        chk("rst_trg_o", trg_o, 0);
        chk("rst_trg_id", trg_id_o, 0);
        chk("rst_trg_cnt", trg_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
        chk("rst_busy_o", busy_o, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Single request from source 2
        trg_req_i[2] = 1'b1;
        idle_cycles(20);
        trg_req_i[2] = 1'b0;
        idle_cycles(2);
        chk("single_cnt", trg_cnt_o, 1);
        chk("single_id", trg_id_o, 2);

        // Priority: sources 1 and 3 together
        set_cfg(4'hF, 2, 0, 0);
        trg_req_i = 4'b1010;
        idle_cycles(15);
        trg_req_i = '0;
        idle_cycles(3);
        chk("prio_cnt", trg_cnt_o, 3);
        chk("prio_last_id", trg_id_o, 3);
        chk("prio_miss", miss_cnt_o, 0);

        // Busy veto, then a re-edge during hold-off
        set_cfg(4'hF, 2, 6, 0);
        busy_i = 1'b1;
        trg_req_i[0] = 1'b1;
        idle_cycles(8);
        chk("veto_no_pulse", trg_cnt_o, 3);
        busy_i = 1'b0;
        wait_trg(10, "veto_release");
        trg_req_i[0] = 1'b0;
        idle_cycles(1);
        trg_req_i[0] = 1'b1;
        idle_cycles(15);
        trg_req_i = '0;
        chk("veto_miss", miss_cnt_o, 1);
        chk("veto_cnt", trg_cnt_o, 4);

        // Periodic source, then stopped
        set_cfg(4'hF, 1, 0, 10);
        idle_cycles(45);
        period_i = '0;
        idle_cycles(20);
        chk("periodic_id", trg_id_o, 4);

        // Masked source and zero pulse length
        set_cfg(4'b1110, 0, 0, 0);
        trg_req_i[0] = 1'b1;
        idle_cycles(10);
        chk("mask_no_miss", miss_cnt_o, 1);
        trg_req_i[1] = 1'b1;
        idle_cycles(10);
        trg_req_i = '0;
        chk("mask_id", trg_id_o, 1);

        // Asynchronous reset during a pulse
        set_cfg(4'hF, 8, 2, 0);
        idle_cycles(2);
        trg_req_i[2] = 1'b1;
        wait_trg(10, "reset_pulse_start");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_trg_o", trg_o, 0);
        chk("arst_trg_id", trg_id_o, 0);
        chk("arst_trg_cnt", trg_cnt_o, 0);
        chk("arst_miss_cnt", miss_cnt_o, 0);
        chk("arst_busy_o", busy_o, 0);
        idle_cycles(2);
        trg_req_i = '0;
        rst_n = 1'b1;
        idle_cycles(2);
        trg_req_i[3] = 1'b1;
        wait_trg(10, "post_reset_grant");
        idle_cycles(15);
        trg_req_i = '0;
        chk("post_reset_cnt", trg_cnt_o, 1);
        chk("post_reset_id", trg_id_o, 3);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                set_cfg(NSRC'($urandom_range(0, 15)), $urandom_range(0, 15), $urandom_range(0, 10),
                        ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(7, 40));
            end
            for (int b = 0; b < NSRC; b++) begin
                if ($urandom_range(0, 7) == 0) trg_req_i[b] = ~trg_req_i[b];
            end
            busy_i = ($urandom_range(0, 3) == 0);
            en_i   = ($urandom_range(0, 49) != 0);
            idle_cycles(1);
        end

        // Drain everything still pending
        trg_req_i = '0;
        busy_i    = 1'b0;
        en_i      = 1'b1;
        period_i  = '0;
        idle_cycles(200);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
